// File: rtl/lcd_pkg.sv
// Shared panel timing definitions for the LCD raster and pattern stages.
package lcd_pkg;

    // Coordinate widths carried on Columna / Fila
    localparam int COL_W = 11;
    localparam int ROW_W = 10;

    // Default timing for the 800x480 parallel-RGB panel
    localparam int DEF_BACK_PORCH_X  = 216;
    localparam int DEF_BACK_PORCH_Y  = 35;
    localparam int DEF_FRONT_PORCH_X = 40;
    localparam int DEF_FRONT_PORCH_Y = 10;
    localparam int DEF_SCREEN_SIZE_X = 800;
    localparam int DEF_SCREEN_SIZE_Y = 480;
    localparam int DEF_HSYNC_WIDTH   = 1;
    localparam int DEF_VSYNC_WIDTH   = 1;
    localparam int DEF_CLK_DIV       = 2;
    localparam int DEF_GREST_DELAY   = 16;

    typedef logic [COL_W-1:0] col_t;
    typedef logic [ROW_W-1:0] row_t;

    // Pixels per line including porches
    function automatic int h_total(input int back_porch, input int screen, input int front_porch);
        return back_porch + screen + front_porch;
    endfunction

    // Lines per frame including porches
    function automatic int v_total(input int back_porch, input int screen, input int front_porch);
        return back_porch + screen + front_porch;
    endfunction

endpackage

// File: rtl/lcd_pix_clk_div.sv
// Pixel clock divider: free-running modulo-CLK_DIV counter, registered NCLK
// and a one-cycle tick on the last CLK of each pixel period.
module lcd_pix_clk_div #(
    parameter int CLK_DIV = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    output logic o_nclk,
    output logic o_tick
);

    localparam int DIV_W = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);

    logic [DIV_W-1:0] r_div_cnt;
    logic [DIV_W-1:0] w_div_next;
    logic             w_tick;
    logic             r_nclk;

    assign w_tick = (r_div_cnt == DIV_LAST);

    // Next divider phase: wrap after the last CLK of the pixel
    always_comb begin
        w_div_next = r_div_cnt + DIV_W'(1);
        if (w_tick) begin
            w_div_next = '0;
        end
    end

    // NCLK is decoded from the next phase so it is a clean flop output that
    // falls on the same edge where the raster counters move
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_div_cnt <= '0;
            r_nclk    <= 1'b0;
        end else begin
            r_div_cnt <= w_div_next;
            r_nclk    <= (w_div_next >= DIV_HALF);
        end
    end

    assign o_nclk = r_nclk;
    assign o_tick = w_tick;

endmodule

// File: rtl/lcd_timing_gen.sv
// Raster timing generator: pixel clock, panel global reset sequencing,
// horizontal/vertical counters and registered HD/VD/DEN decodes.
module lcd_timing_gen
    import lcd_pkg::*;
#(
    parameter int BACK_PORCH_X  = DEF_BACK_PORCH_X,
    parameter int BACK_PORCH_Y  = DEF_BACK_PORCH_Y,
    parameter int FRONT_PORCH_X = DEF_FRONT_PORCH_X,
    parameter int FRONT_PORCH_Y = DEF_FRONT_PORCH_Y,
    parameter int SCREEN_SIZE_X = DEF_SCREEN_SIZE_X,
    parameter int SCREEN_SIZE_Y = DEF_SCREEN_SIZE_Y,
    parameter int HSYNC_WIDTH   = DEF_HSYNC_WIDTH,
    parameter int VSYNC_WIDTH   = DEF_VSYNC_WIDTH,
    parameter int CLK_DIV       = DEF_CLK_DIV,
    parameter int GREST_DELAY   = DEF_GREST_DELAY
) (
    input  logic             CLK,
    input  logic             RST_n,
    output logic             NCLK,
    output logic             GREST,
    output logic             HD,
    output logic             VD,
    output logic             DEN,
    output logic [COL_W-1:0] Columna,
    output logic [ROW_W-1:0] Fila
);

    localparam int H_TOTAL = h_total(BACK_PORCH_X, SCREEN_SIZE_X, FRONT_PORCH_X);
    localparam int V_TOTAL = v_total(BACK_PORCH_Y, SCREEN_SIZE_Y, FRONT_PORCH_Y);
    localparam int H_ACT_END = BACK_PORCH_X + SCREEN_SIZE_X;
    localparam int V_ACT_END = BACK_PORCH_Y + SCREEN_SIZE_Y;
    localparam int GREST_W = $clog2(GREST_DELAY + 1);

    // Parameter sanity, caught at elaboration rather than in silicon
    generate
        if (H_TOTAL > (1 << COL_W)) begin : g_chk_h_total
            $error("lcd_timing_gen: H_TOTAL does not fit in Columna");
        end
        if (V_TOTAL > (1 << ROW_W)) begin : g_chk_v_total
            $error("lcd_timing_gen: V_TOTAL does not fit in Fila");
        end
        if (HSYNC_WIDTH >= BACK_PORCH_X) begin : g_chk_hsync
            $error("lcd_timing_gen: HSYNC_WIDTH must be below BACK_PORCH_X");
        end
        if (VSYNC_WIDTH >= BACK_PORCH_Y) begin : g_chk_vsync
            $error("lcd_timing_gen: VSYNC_WIDTH must be below BACK_PORCH_Y");
        end
        if ((CLK_DIV < 2) || ((CLK_DIV % 2) != 0)) begin : g_chk_div
            $error("lcd_timing_gen: CLK_DIV must be even and at least 2");
        end
        if (GREST_DELAY < 1) begin : g_chk_grest
            $error("lcd_timing_gen: GREST_DELAY must be at least 1");
        end
    endgenerate

    localparam col_t H_LAST = COL_W'(H_TOTAL - 1);
    localparam row_t V_LAST = ROW_W'(V_TOTAL - 1);
    localparam logic [GREST_W-1:0] GREST_LAST = GREST_W'(GREST_DELAY - 1);

    logic               w_tick;
    logic               w_nclk;
    logic               w_advance;
    logic [GREST_W-1:0] r_grest_cnt;
    logic               r_grest;
    col_t               r_col;
    row_t               r_row;
    col_t               w_col_next;
    row_t               w_row_next;
    logic               r_hd;
    logic               r_vd;
    logic               r_den;
    logic               w_hd_next;
    logic               w_vd_next;
    logic               w_den_next;

    lcd_pix_clk_div #(
        .CLK_DIV (CLK_DIV)
    ) u_pix_clk_div (
        .i_clk   (CLK),
        .i_rst_n (RST_n),
        .o_nclk  (w_nclk),
        .o_tick  (w_tick)
    );

    // Raster only moves once the panel is out of global reset
    assign w_advance = r_grest & w_tick;

    // Hold GREST low for GREST_DELAY CLK cycles after reset release, then latch high
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            r_grest_cnt <= '0;
            r_grest     <= 1'b0;
        end else if (!r_grest) begin
            r_grest_cnt <= r_grest_cnt + GREST_W'(1);
            if (r_grest_cnt == GREST_LAST) begin
                r_grest <= 1'b1;
            end
        end
    end

    // Next raster position: column wraps into the next row, row wraps with it
    always_comb begin
        w_col_next = r_col;
        w_row_next = r_row;
        if (w_advance) begin
            if (r_col == H_LAST) begin
                w_col_next = '0;
                if (r_row == V_LAST) begin
                    w_row_next = '0;
                end else begin
                    w_row_next = r_row + ROW_W'(1);
                end
            end else begin
                w_col_next = r_col + COL_W'(1);
            end
        end
    end

    // Sync/enable decoded from the next position so they register alongside it;
    // compares are done at 32-bit width so no boundary is ever truncated
    always_comb begin
        w_hd_next  = !(int'(w_col_next) < HSYNC_WIDTH);
        w_vd_next  = !(int'(w_row_next) < VSYNC_WIDTH);
        w_den_next = (int'(w_col_next) >= BACK_PORCH_X) && (int'(w_col_next) < H_ACT_END) &&
                     (int'(w_row_next) >= BACK_PORCH_Y) && (int'(w_row_next) < V_ACT_END);
    end

    // Raster state and decodes update together on the edge after a pixel tick
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            r_col <= '0;
            r_row <= '0;
            r_hd  <= 1'b1;
            r_vd  <= 1'b1;
            r_den <= 1'b0;
        end else if (w_advance) begin
            r_col <= w_col_next;
            r_row <= w_row_next;
            r_hd  <= w_hd_next;
            r_vd  <= w_vd_next;
            r_den <= w_den_next;
        end
    end

    assign NCLK    = w_nclk;
    assign GREST   = r_grest;
    assign HD      = r_hd;
    assign VD      = r_vd;
    assign DEN     = r_den;
    assign Columna = r_col;
    assign Fila    = r_row;

endmodule

// File: tb/tb_lcd_timing_gen.sv
// Self-checking bench for lcd_timing_gen using a reduced panel geometry so
// several frames fit in a short run. Expected outputs come from a closed-form
// model indexed by CLK edges since reset release.
module tb_lcd_timing_gen;

    localparam int BPX = 6;
    localparam int SSX = 8;
    localparam int FPX = 3;
    localparam int BPY = 3;
    localparam int SSY = 4;
    localparam int FPY = 2;
    localparam int HS  = 2;
    localparam int VS  = 1;
    localparam int D   = 4;
    localparam int G   = 16;
    localparam int H   = BPX + SSX + FPX;
    localparam int V   = BPY + SSY + FPY;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        nclk;
    logic        grest;
    logic        hd;
    logic        vd;
    logic        den;
    logic [10:0] columna;
    logic [9:0]  fila;

    int n_checks = 0;
    int n_pass   = 0;
    int n_edges  = 0;
    int txn      = 0;

    logic [25:0] exp_q[$];

    lcd_timing_gen #(
        .BACK_PORCH_X  (BPX),
        .BACK_PORCH_Y  (BPY),
        .FRONT_PORCH_X (FPX),
        .FRONT_PORCH_Y (FPY),
        .SCREEN_SIZE_X (SSX),
        .SCREEN_SIZE_Y (SSY),
        .HSYNC_WIDTH   (HS),
        .VSYNC_WIDTH   (VS),
        .CLK_DIV       (D),
        .GREST_DELAY   (G)
    ) dut (
        .CLK     (clk),
        .RST_n   (rst_n),
        .NCLK    (nclk),
        .GREST   (grest),
        .HD      (hd),
        .VD      (vd),
        .DEN     (den),
        .Columna (columna),
        .Fila    (fila)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Expected {NCLK,GREST,HD,VD,DEN,Columna,Fila} after n CLK edges since release
    function automatic logic [25:0] model(input int n);
        int   p;
        int   col;
        int   row;
        logic started;
        logic m_hd;
        logic m_vd;
        logic m_den;
        logic m_grest;
        logic m_nclk;
        // Pixel advances happen on edges that are multiples of D, once GREST was already high
        p       = (n > G) ? (n / D - G / D) : 0;
        col     = p % H;
        row     = (p / H) % V;
        started = (p > 0);
        m_hd    = started ? !(col < HS) : 1'b1;
        m_vd    = started ? !(row < VS) : 1'b1;
        m_den   = started && (col >= BPX) && (col < BPX + SSX) && (row >= BPY) && (row < BPY + SSY);
        m_grest = (n >= G);
        m_nclk  = ((n % D) >= D / 2);
        return {m_nclk, m_grest, m_hd, m_vd, m_den, 11'(col), 10'(row)};
    endfunction

    function automatic logic [25:0] observed();
        return {nclk, grest, hd, vd, den, columna, fila};
    endfunction

    // Each cycle: push the expectation at the edge, pop and compare half a cycle later
    task automatic run(input int num);
        logic [25:0] e;
        logic [25:0] o;
        repeat (num) begin
            @(posedge clk);
            if (rst_n) n_edges++;
            exp_q.push_back(model(n_edges));
            @(negedge clk);
            o = observed();
            e = exp_q.pop_front();
            check_val("raster", {6'd0, o}, {6'd0, e});
            txn++;
            $display("txn %0d rst_n=%b n=%0d col=%0d row=%0d hd=%b vd=%b den=%b grest=%b nclk=%b",
                     txn, rst_n, n_edges, columna, fila, hd, vd, den, grest, nclk);
        end
    endtask

    // Interval monitor: line, sync-width, enable-window and frame measurements
    int   cyc = 0;
    int   hd_falls = 0;
    int   hd_fall_t = 0;
    int   vd_falls = 0;
    int   vd_fall_t = 0;
    int   den_cnt = 0;
    int   den_rise_t = 0;
    logic prev_hd = 1'b1;
    logic prev_vd = 1'b1;
    logic prev_den = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            cyc      = 0;
            hd_falls = 0;
            vd_falls = 0;
            den_cnt  = 0;
            prev_hd  = 1'b1;
            prev_vd  = 1'b1;
            prev_den = 1'b0;
        end else begin
            cyc++;
            if (prev_hd && !hd) begin
                if (hd_falls >= 2) check_val("hd_period", cyc - hd_fall_t, H * D);
                hd_falls++;
                hd_fall_t = cyc;
            end
            if (!prev_hd && hd && hd_falls >= 2) check_val("hd_low", cyc - hd_fall_t, HS * D);
            if (den) den_cnt++;
            if (!prev_den && den) den_rise_t = cyc;
            if (prev_den && !den) begin
                check_val("den_run", cyc - den_rise_t, SSX * D);
                check_val("den_fall_col", {21'd0, columna}, BPX + SSX);
            end
            if (prev_vd && !vd) begin
                check_val("hdvd_align", {31'd0, hd}, 0);
                if (vd_falls >= 1) check_val("den_per_frame", den_cnt, SSX * SSY * D);
                if (vd_falls >= 2) check_val("vd_period", cyc - vd_fall_t, H * V * D);
                vd_falls++;
                vd_fall_t = cyc;
                den_cnt   = 0;
            end
            prev_hd  = hd;
            prev_vd  = vd;
            prev_den = den;
        end
    end

    initial begin
        logic [25:0] m;
        logic        found;
        // Reset held: outputs at reset values
        rst_n = 1'b0;
        run(10);
        #2 rst_n = 1'b1;
        // GREST sequence, raster start and two full frames including the wrap
        run(1300);
        // Advance to a mid-frame position
        found = 1'b0;
        for (int i = 0; i < 2000 && !found; i++) begin
            run(1);
            m = model(n_edges);
            if (m[20:10] == 11'd10 && m[9:0] == 10'd5) found = 1'b1;
        end
        check_val("find_mid", {31'd0, found}, 1);
        // Asynchronous reset away from any clock edge
        #2 rst_n = 1'b0;
        #1 check_val("async_rst", {6'd0, observed()}, {6'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 11'd0, 10'd0});
        n_edges = 0;
        run(5);
        #2 rst_n = 1'b1;
        // GREST delay repeats and raster restarts from 0/0
        run(700);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
